// File: rtl/sram_to_sram_read.sv
// Sequential read stage: sweeps two source SRAMs in lockstep and
// streams the aligned words downstream as data0/data1/valid.
module sram_to_sram_read #(
  parameter int ADDR_BITS   = 10,
  parameter int DATA_BITS   = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem0_ren,
  output logic [ADDR_BITS-1:0] mem0_raddr,
  input  logic [DATA_BITS-1:0] mem0_rdata,
  output logic                 mem1_ren,
  output logic [ADDR_BITS-1:0] mem1_raddr,
  input  logic [DATA_BITS-1:0] mem1_rdata,
  output logic [DATA_BITS-1:0] m_data0,
  output logic [DATA_BITS-1:0] m_data1,
  output logic                 m_valid
);

  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [DATA_BITS-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [MEM_LATENCY-1:0] vp;
  logic                   ren_nx;
  addr_t                  raddr_nx;
  logic                   done_nx;

  assign mem1_ren   = mem0_ren;
  assign mem1_raddr = mem0_raddr;

  // The registered raddr doubles as the sweep counter.
  always_comb begin
    state_nx = state;
    ren_nx   = 1'b0;
    raddr_nx = mem0_raddr;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !done) begin
          state_nx = RUN;
          ren_nx   = 1'b1;
          raddr_nx = '0;
        end
      end
      RUN: begin
        if (&mem0_raddr) begin
          state_nx = DRAIN;
          raddr_nx = '0;
        end else begin
          ren_nx   = 1'b1;
          raddr_nx = mem0_raddr + addr_t'(1);
        end
      end
      DRAIN: begin
        if (vp == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem0_ren   <= 1'b0;
      mem0_raddr <= '0;
      vp         <= '0;
      m_valid    <= 1'b0;
      m_data0    <= '0;
      m_data1    <= '0;
    end else if (cke) begin
      state      <= state_nx;
      busy       <= (state_nx != IDLE);
      done       <= done_nx;
      mem0_ren   <= ren_nx;
      mem0_raddr <= raddr_nx;
      vp         <= MEM_LATENCY'({vp, mem0_ren});
      m_valid    <= vp[MEM_LATENCY-1];
      if (vp[MEM_LATENCY-1]) begin
        m_data0 <= data_t'(mem0_rdata);
        m_data1 <= data_t'(mem1_rdata);
      end
    end
  end

endmodule
